muldiv_ctrl: RTL

Sequencing controller for the EX-stage multiply/divide unit. It accepts a mult/multu/div/divu issue from EX, latches the operands, and runs a fixed-latency cycle counter. It drives Busy and the HI/LO write enable, and raises the decode-stage stall for any HI/LO-touching instruction while the unit is occupied. It sits between the hazard unit (ID stall) and the arithmetic core, which computes combinationally from the latched operands.

---
 rtl/muldiv_ctrl_pkg.sv | 19 +
 rtl/muldiv_ctrl_if.sv | 34 +++
 rtl/muldiv_ctrl_md_counter.sv | 26 ++
 rtl/muldiv_ctrl.sv | 114 +++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings and cycle-count defaults for the multiply/divide sequencer.
package muldiv_ctrl_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MUL_RUN = 2'd1;
  localparam logic [1:0] ST_DIV_RUN = 2'd2;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam int CNT_W_DEF      = 4;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// EX/ID-side request signals and controller outputs toward HI/LO, the core and hazard unit.
interface muldiv_ctrl_if;

  logic        id_md_use;
  logic        ex_start;
  logic [1:0]  ex_op;
  logic [31:0] ex_d1;
  logic [31:0] ex_d2;
  logic        ex_mt;
  logic        ex_mt_hi;
  logic        flush;

  logic [31:0] md_a;
  logic [31:0] md_b;
  logic [1:0]  md_op;
  logic        Busy;
  logic        done;
  logic        hi_we;
  logic        lo_we;
  logic        hilo_src;
  logic        stall_id;
  logic        md_err;

  modport master (
    output id_md_use, ex_start, ex_op, ex_d1, ex_d2, ex_mt, ex_mt_hi, flush,
    input  md_a, md_b, md_op, Busy, done, hi_we, lo_we, hilo_src, stall_id, md_err
  );

  modport slave (
    input  id_md_use, ex_start, ex_op, ex_d1, ex_d2, ex_mt, ex_mt_hi, flush,
    output md_a, md_b, md_op, Busy, done, hi_we, lo_we, hilo_src, stall_id, md_err
  );

endinterface

// File: rtl/muldiv_ctrl_md_counter.sv
// Loadable down-counter with zero flag; load has priority, decrement saturates at 0.
module md_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: operand latch, fixed-latency busy counter, HI/LO write and ID stall.
// Optional MD_DIV_EARLY_EN: div/divu with a zero divisor completes after a single busy cycle.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_ctrl_if.slave  md
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             idle;
  logic             start_acc;
  logic             mt_acc;
  logic             done_int;
  logic             violation;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] div_load_val;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [1:0]       op_q;
  logic             err_q;

  assign idle = (state == ST_IDLE);

  // Flush squashes both kinds of request and the final-cycle write-back.
  assign start_acc = idle & md.ex_start & ~md.flush;
  assign mt_acc    = idle & md.ex_mt & ~md.ex_start & ~md.flush;
  assign done_int  = ~idle & cnt_zero & ~md.flush;
  assign violation = (~idle & (md.ex_start | md.ex_mt)) | (md.ex_start & md.ex_mt);

`ifdef MD_DIV_EARLY_EN
  assign div_load_val = (md.ex_d2 == 32'd0) ? '0 : DIV_LOAD;
`else
  assign div_load_val = DIV_LOAD;
`endif

  // Reload to zero on flush so a later start never sees a stale count.
  assign cnt_load     = start_acc | md.flush;
  assign cnt_load_val = md.flush ? '0 : (md.ex_op[1] ? div_load_val : MUL_LOAD);

  always_comb begin
    state_nxt = state;
    if (md.flush) begin
      state_nxt = ST_IDLE;
    end else if (start_acc) begin
      state_nxt = md.ex_op[1] ? ST_DIV_RUN : ST_MUL_RUN;
    end else if (done_int) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  md_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (~idle),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (start_acc) begin
      a_q  <= md.ex_d1;
      b_q  <= md.ex_d2;
      op_q <= md.ex_op;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (violation) begin
      err_q <= 1'b1;
    end
  end

  assign md.md_a     = a_q;
  assign md.md_b     = b_q;
  assign md.md_op    = op_q;
  assign md.Busy     = ~idle;
  assign md.done     = done_int;
  assign md.hi_we    = done_int | (mt_acc & md.ex_mt_hi);
  assign md.lo_we    = done_int | (mt_acc & ~md.ex_mt_hi);
  assign md.hilo_src = mt_acc;
  assign md.stall_id = md.id_md_use & (~idle | md.ex_start);
  assign md.md_err   = err_q;

endmodule
